fp_add_normalize: RTL
=====================

# fp_add_normalize

Significand add/subtract and normalization stage of the IEEE 754 floating-point adder. It sits directly downstream of the alignment stage. It receives the larger operand and the exponent-aligned smaller operand, both as `fp_pkg::float`, and adds or subtracts their significands. It then renormalizes the result with an iterative one-bit-per-cycle shifter and returns a packed `float` over a valid/ready handshake.

## Interface
- `FRAC_W`, default `fp_pkg::FRACTION_BITS`: fraction width; the exponent width follows `float.exp`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `bign`  in  float  larger-exponent operand; hidden bit = (`bign.exp != 0`).
- `aligned`  in  float  smaller operand already shifted; `aligned.exp` equals `bign.exp`.
- `aligned_hid`  in  1  hidden bit of the aligned significand (1 only when the shift was 0).
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  float  sum, truncated with no rounding.
- `out_ovf`  out  1  result overflowed to infinity.

## Operation
- FSM states: IDLE, ADD, NORM, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`, latch the operands and go to ADD.
- **ADD** (one cycle)
  - `sb={hid_b,bign.frac}`, `ss={aligned_hid,aligned.frac}`, each FRAC_W+1 bits; the sum is FRAC_W+2 bits.
  - Same signs: `sum=sb+ss`, sign = `bign.sign`.
    - On carry-out, shift right 1 (drop the LSB) and increment exp.
    - If the incremented exp is all-ones, set frac=0 and `out_ovf=1`.
  - Different signs with `sb>=ss`: `sum=sb-ss`, sign = `bign.sign`. With `ss>sb`: `sum=ss-sb`, sign = `aligned.sign`.
  - Result zero: output +0 (sign 0, exp 0, frac 0).
  - Next state: NORM if the hidden bit is 0 and exp > 1. Otherwise DONE.
- **NORM** (one shift per cycle)
  - Each cycle: significand <<1, exp−1.
  - Leave for DONE when the hidden bit is 1, or when exp reaches 1 with the hidden bit still 0. In the second case, emit a subnormal: exp=0, frac unchanged.
  - At most FRAC_W cycles.
- **DONE**
  - `out_valid=1`; `result` and `out_ovf` are stable.
  - On `out_ready`, go to IDLE.
- A nonzero result with exp 0 entering ADD and no carry goes straight to DONE, exp 0.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `result=0`, `out_ovf=0`.
- Registered outputs; no combinational path from `in_valid`/`out_ready` to any output other than the next-state logic.
- Latency from the accepting edge to `out_valid`:
  - 2 cycles with no normalization shift.
  - 2+k cycles with k shifts; worst case 2+FRAC_W.
- Throughput: one operation in flight. Next accept no earlier than the cycle after the `out_valid && out_ready` edge.
- `in_valid` while busy is ignored; `in_ready=0` outside IDLE.
- Async reset asserted in any state: the reset values above apply immediately. The in-flight operation is discarded and no `out_valid` pulse is produced.
- `out_ready` held low: DONE persists and outputs stay bit-stable indefinitely.

## Configuration
- `FP_ADD_SPECIALS_EN`
  - Defined: ADD checks for all-ones exponents.
    - `bign` NaN → `bign` with frac MSB forced to 1.
    - Both infinite with opposite signs → canonical quiet NaN (sign 0, exp all-ones, frac MSB 1 only).
    - Otherwise infinite `bign` → `bign` unchanged.
    - All of these go directly to DONE with `out_ovf=0`.
  - Undefined: no special-value detection; all-ones exponents are processed arithmetically.

## Test plan
Single precision, FRAC_W=23.
- 1.0+1.0: `bign`=0x3F800000, `aligned`=0x3F800000, `aligned_hid=1` → `result` 0x40000000, `out_ovf=0`, `out_valid` 2 cycles after accept.
- 1.0−1.0: `aligned` sign 1, same fields → `result` 0x00000000, latency 2.
- 1.5−1.25: `bign`=0x3FC00000, `aligned`=0xBFA00000, `aligned_hid=1` → `result` 0x3E800000 (0.25), latency 4 (two NORM shifts).
- Overflow: `bign`=0x7F7FFFFF + `aligned`=0x7F7FFFFF, `aligned_hid=1` → `result` 0x7F800000, `out_ovf=1`.
- Backpressure and reset:
  - Hold `out_ready=0` for 5 cycles in DONE: `result` stable, `in_ready=0`, new `in_valid` ignored. Release → IDLE next cycle.
  - Then assert `rst_n=0` during NORM of the 1.5−1.25 case: `out_valid` never pulses and `in_ready=1` after release.
- With `FP_ADD_SPECIALS_EN`: +inf (0x7F800000) plus −inf → 0x7FC00000, latency 2.

Source files
------------

// File: rtl/fp_add_normalize.sv
// Significand add/subtract and iterative one-bit normalizer for the FP adder.
// Optional special-value handling is enabled by defining FP_ADD_SPECIALS_EN.
package fp_pkg;
  localparam int EXPONENT_BITS = 8;
  localparam int FRACTION_BITS = 23;
  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exp;
    logic [FRACTION_BITS-1:0] frac;
  } float;
endpackage

module fp_add_normalize #(
  parameter int FRAC_W = fp_pkg::FRACTION_BITS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [fp_pkg::EXPONENT_BITS+FRAC_W:0] bign,
  input  logic [fp_pkg::EXPONENT_BITS+FRAC_W:0] aligned,
  input  logic                                aligned_hid,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [fp_pkg::EXPONENT_BITS+FRAC_W:0] result,
  output logic                                out_ovf,
  output logic [1:0]                          o_dbg_state
);

  localparam int EXP_W = fp_pkg::EXPONENT_BITS;
  localparam int SIG_W = FRAC_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid holds its payload stable until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_sign_b;
  logic             r_sign_a;
  logic [EXP_W-1:0] r_exp_in;
  logic [SIG_W-1:0] r_sb;
  logic [SIG_W-1:0] r_ss;
  logic             r_sign;
  logic [EXP_W-1:0] r_exp;
  logic [SIG_W-1:0] r_sig;
  logic             r_ovf;

  logic             w_same;
  logic             w_b_ge;
  logic [SIG_W:0]   w_sum;
  logic [EXP_W:0]   w_exp_inc;
  logic             w_add_sign;
  logic [EXP_W-1:0] w_add_exp;
  logic [SIG_W-1:0] w_add_sig;
  logic             w_add_ovf;
  logic             w_add_norm;
  logic [SIG_W-1:0] w_norm_sig;
  logic [EXP_W-1:0] w_norm_exp;

  always_comb begin
    w_same     = (r_sign_b == r_sign_a);
    w_b_ge     = (r_sb >= r_ss);
    w_exp_inc  = {1'b0, r_exp_in} + {{EXP_W{1'b0}}, 1'b1};
    if (w_same)      w_sum = {1'b0, r_sb} + {1'b0, r_ss};
    else if (w_b_ge) w_sum = {1'b0, r_sb} - {1'b0, r_ss};
    else             w_sum = {1'b0, r_ss} - {1'b0, r_sb};
    w_add_sign = (w_same || w_b_ge) ? r_sign_b : r_sign_a;
    w_add_exp  = r_exp_in;
    w_add_sig  = w_sum[SIG_W-1:0];
    w_add_ovf  = 1'b0;
    w_add_norm = 1'b0;

    if (w_sum == '0) begin
      w_add_sign = 1'b0;
      w_add_exp  = '0;
      w_add_sig  = '0;
    end else if (w_sum[SIG_W]) begin
      w_add_sig = w_sum[SIG_W:1];
      if (w_exp_inc >= {1'b0, EXP_ONES}) begin
        w_add_exp = EXP_ONES;
        w_add_sig = {1'b1, {FRAC_W{1'b0}}};
        w_add_ovf = 1'b1;
      end else begin
        w_add_exp = w_exp_inc[EXP_W-1:0];
      end
    end else if (!w_sum[FRAC_W]) begin
      if (r_exp_in > EXP_W'(1)) w_add_norm = 1'b1;
      else                      w_add_exp  = '0;
    end else if (r_exp_in == '0) begin
      // Two subnormals whose sum reaches the hidden bit become normal.
      w_add_exp = EXP_W'(1);
    end

`ifdef FP_ADD_SPECIALS_EN
    if (r_exp_in == EXP_ONES) begin
      w_add_exp  = EXP_ONES;
      w_add_ovf  = 1'b0;
      w_add_norm = 1'b0;
      if (r_sb[FRAC_W-1:0] != '0) begin
        w_add_sign = r_sign_b;
        w_add_sig  = {r_sb[FRAC_W], 1'b1, r_sb[FRAC_W-2:0]};
      end else if ((r_ss[FRAC_W-1:0] == '0) && (r_sign_a != r_sign_b)) begin
        w_add_sign = 1'b0;
        w_add_sig  = {1'b1, 1'b1, {(FRAC_W-1){1'b0}}};
      end else begin
        w_add_sign = r_sign_b;
        w_add_sig  = r_sb;
      end
    end
`endif
  end

  assign w_norm_sig = {r_sig[SIG_W-2:0], 1'b0};
  assign w_norm_exp = r_exp - EXP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = ADD;
      ADD:  w_next = w_add_norm ? NORM : DONE;
      NORM: if (w_norm_sig[FRAC_W] || (w_norm_exp == EXP_W'(1))) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_b <= 1'b0;
      r_sign_a <= 1'b0;
      r_exp_in <= '0;
      r_sb     <= '0;
      r_ss     <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_sig    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sign_b <= bign[EXP_W+FRAC_W];
          r_exp_in <= bign[EXP_W+FRAC_W-1:FRAC_W];
          r_sb     <= {(bign[EXP_W+FRAC_W-1:FRAC_W] != '0), bign[FRAC_W-1:0]};
          r_sign_a <= aligned[EXP_W+FRAC_W];
          r_ss     <= {aligned_hid, aligned[FRAC_W-1:0]};
        end
        ADD: begin
          r_sign <= w_add_sign;
          r_exp  <= w_add_exp;
          r_sig  <= w_add_sig;
          r_ovf  <= w_add_ovf;
        end
        NORM: begin
          r_sig <= w_norm_sig;
          // Reaching exp 1 without a hidden bit leaves a subnormal encoding.
          r_exp <= (!w_norm_sig[FRAC_W] && (w_norm_exp == EXP_W'(1))) ? '0 : w_norm_exp;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign result      = {r_sign, r_exp, r_sig[FRAC_W-1:0]};
  assign out_ovf     = r_ovf;
  assign o_dbg_state = r_state;

endmodule
